// File: rtl/xor_skid_stage.sv
// Registered XOR stage with a 2-entry skid buffer and per-frame parity of delivered beats.
// Optional assertions are enabled by defining XOR_SKID_STAGE_ASSERT_EN.
module xor_skid_stage #(
    parameter int WIDTH     = 1,
    parameter int DOIT      = 1,
    parameter int FRAME_LEN = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_c,
    output logic             frame_done,
    output logic             frame_parity
);

    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } cnt_e;

    cnt_e             r_count;
    cnt_e             w_count_next;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [WIDTH-1:0] w_head_next;
    logic [WIDTH-1:0] w_tail_next;
    logic [WIDTH-1:0] w_result;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    r_beat;
    logic             r_acc;
    logic             w_acc_next;
    logic             r_frame_done;
    logic             r_frame_parity;

    assign w_result     = (DOIT != 0) ? (in_a ^ in_b) : {WIDTH{1'b0}};
    assign in_ready     = (r_count != FULL);
    assign out_valid    = (r_count != EMPTY);
    assign out_c        = r_head;
    assign w_push       = in_valid & in_ready;
    assign w_pop        = out_valid & out_ready;
    assign w_acc_next   = r_acc ^ (^r_head);
    assign frame_done   = r_frame_done;
    assign frame_parity = r_frame_parity;

    // Buffer next-state: occupancy plus head/tail contents.
    always_comb begin
        w_count_next = r_count;
        w_head_next  = r_head;
        w_tail_next  = r_tail;
        case (r_count)
            EMPTY: begin
                if (w_push) begin
                    w_count_next = ONE;
                    w_head_next  = w_result;
                end else begin
                    w_count_next = EMPTY;
                end
            end
            ONE: begin
                if (w_push && w_pop) begin
                    w_head_next = w_result;
                end else if (w_push) begin
                    w_count_next = FULL;
                    w_tail_next  = w_result;
                end else if (w_pop) begin
                    w_count_next = EMPTY;
                end else begin
                    w_count_next = ONE;
                end
            end
            FULL: begin
                // in_ready is low here, so only a pop can move the buffer.
                if (w_pop) begin
                    w_count_next = ONE;
                    w_head_next  = r_tail;
                end else begin
                    w_count_next = FULL;
                end
            end
            default: begin
                w_count_next = EMPTY;
            end
        endcase
    end

    // Buffer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= EMPTY;
            r_head  <= {WIDTH{1'b0}};
            r_tail  <= {WIDTH{1'b0}};
        end else begin
            r_count <= w_count_next;
            r_head  <= w_head_next;
            r_tail  <= w_tail_next;
        end
    end

    // Frame beat counter and parity accumulator; pulses frame_done after the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat         <= {CW{1'b0}};
            r_acc          <= 1'b0;
            r_frame_done   <= 1'b0;
            r_frame_parity <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_pop) begin
                if (r_beat == LAST_BEAT) begin
                    r_beat         <= {CW{1'b0}};
                    r_acc          <= 1'b0;
                    r_frame_done   <= 1'b1;
                    r_frame_parity <= w_acc_next;
                end else begin
                    r_beat <= r_beat + CW'(1);
                    r_acc  <= w_acc_next;
                end
            end
        end
    end

`ifdef XOR_SKID_STAGE_ASSERT_EN
    logic             r_stall_prev;
    logic [WIDTH-1:0] r_c_prev;

    // Stall-stability, occupancy and DOIT=0 output checks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_prev <= 1'b0;
            r_c_prev     <= {WIDTH{1'b0}};
        end else begin
            r_stall_prev <= out_valid & ~out_ready;
            r_c_prev     <= out_c;
            if (r_stall_prev) begin
                assert (out_valid && (out_c == r_c_prev));
            end
            assert (r_count != 2'd3);
            if ((DOIT == 0) && out_valid) begin
                assert (out_c == {WIDTH{1'b0}});
            end
        end
    end
`endif

endmodule

// File: tb/tb_xor_skid_stage.sv
// Directed self-checking bench for xor_skid_stage using three parameterisations.
module tb_xor_skid_stage;

    logic clk;
    logic rst;

    // Instance A: WIDTH=4, DOIT=1, FRAME_LEN=3
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_frame_done, a_frame_parity;
    logic [3:0] a_in_a, a_in_b, a_out_c;
    // Instance Z: WIDTH=4, DOIT=0, FRAME_LEN=2
    logic       z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_frame_done, z_frame_parity;
    logic [3:0] z_in_a, z_in_b, z_out_c;
    // Instance F: WIDTH=1, DOIT=1, FRAME_LEN=3
    logic       f_in_valid, f_in_ready, f_out_valid, f_out_ready, f_frame_done, f_frame_parity;
    logic [0:0] f_in_a, f_in_b, f_out_c;

    int n_checks;
    int n_errors;

    xor_skid_stage #(.WIDTH(4), .DOIT(1), .FRAME_LEN(3)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_a(a_in_a), .in_b(a_in_b),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_c(a_out_c),
        .frame_done(a_frame_done), .frame_parity(a_frame_parity)
    );

    xor_skid_stage #(.WIDTH(4), .DOIT(0), .FRAME_LEN(2)) u_dut_z (
        .clk(clk), .rst(rst),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_a(z_in_a), .in_b(z_in_b),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_c(z_out_c),
        .frame_done(z_frame_done), .frame_parity(z_frame_parity)
    );

    xor_skid_stage #(.WIDTH(1), .DOIT(1), .FRAME_LEN(3)) u_dut_f (
        .clk(clk), .rst(rst),
        .in_valid(f_in_valid), .in_ready(f_in_ready), .in_a(f_in_a), .in_b(f_in_b),
        .out_valid(f_out_valid), .out_ready(f_out_ready), .out_c(f_out_c),
        .frame_done(f_frame_done), .frame_parity(f_frame_parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_in_valid = 1'b0; z_in_valid = 1'b0; f_in_valid = 1'b0;
        a_out_ready = 1'b0; z_out_ready = 1'b0; f_out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        a_in_a = 4'h0; a_in_b = 4'h0;
        z_in_a = 4'h0; z_in_b = 4'h0;
        f_in_a = 1'b0; f_in_b = 1'b0;
        do_reset();
        tick();

        // Reset values
        check_eq("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        check_eq("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        check_eq("rst_out_c", {28'd0, a_out_c}, 32'd0);
        check_eq("rst_frame_done", {31'd0, a_frame_done}, 32'd0);
        check_eq("rst_frame_parity", {31'd0, a_frame_parity}, 32'd0);
        check_eq("rst_z_out_valid", {31'd0, z_out_valid}, 32'd0);
        check_eq("rst_f_out_valid", {31'd0, f_out_valid}, 32'd0);

        // Basic latency: 5 ^ 3 = 6 visible the cycle after the push
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_a = 4'h5; a_in_b = 4'h3;
        tick();
        a_in_valid = 1'b0;
        check_eq("lat_out_valid", {31'd0, a_out_valid}, 32'd1);
        check_eq("lat_out_c", {28'd0, a_out_c}, 32'h6);
        check_eq("lat_in_ready", {31'd0, a_in_ready}, 32'd1);
        tick();
        check_eq("lat_drained", {31'd0, a_out_valid}, 32'd0);

        // Backpressure: results 1,2,3 with out_ready low
        do_reset();
        a_in_valid = 1'b1; a_in_a = 4'h1; a_in_b = 4'h0;
        tick();
        a_in_a = 4'h2;
        tick();
        check_eq("bp_full_in_ready", {31'd0, a_in_ready}, 32'd0);
        check_eq("bp_head", {28'd0, a_out_c}, 32'h1);
        a_in_a = 4'h3;
        tick();
        check_eq("bp_stall_in_ready", {31'd0, a_in_ready}, 32'd0);
        check_eq("bp_stall_c1", {28'd0, a_out_c}, 32'h1);
        tick();
        check_eq("bp_stall_c2", {28'd0, a_out_c}, 32'h1);
        check_eq("bp_stall_valid", {31'd0, a_out_valid}, 32'd1);
        a_out_ready = 1'b1;
        tick();
        check_eq("bp_second", {28'd0, a_out_c}, 32'h2);
        check_eq("bp_ready_back", {31'd0, a_in_ready}, 32'd1);
        tick();
        a_in_valid = 1'b0;
        check_eq("bp_third", {28'd0, a_out_c}, 32'h3);
        check_eq("bp_third_valid", {31'd0, a_out_valid}, 32'd1);
        tick();
        check_eq("bp_empty", {31'd0, a_out_valid}, 32'd0);
        check_eq("bp_frame_done", {31'd0, a_frame_done}, 32'd1);
        check_eq("bp_frame_parity", {31'd0, a_frame_parity}, 32'd0);
        tick();
        check_eq("bp_frame_done_drop", {31'd0, a_frame_done}, 32'd0);

        // Simultaneous push and pop while holding one entry
        do_reset();
        a_in_valid = 1'b1; a_in_a = 4'h1; a_in_b = 4'h0;
        tick();
        a_out_ready = 1'b1; a_in_a = 4'h7; a_in_b = 4'h0;
        tick();
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        check_eq("pp_out_c", {28'd0, a_out_c}, 32'h7);
        check_eq("pp_in_ready", {31'd0, a_in_ready}, 32'd1);
        a_out_ready = 1'b1;
        tick();
        check_eq("pp_one_entry", {31'd0, a_out_valid}, 32'd0);

        // DOIT=0: results are zero and frame parity is zero
        do_reset();
        z_in_valid = 1'b1; z_in_a = 4'hF; z_in_b = 4'h1;
        tick();
        check_eq("z_out_c", {28'd0, z_out_c}, 32'h0);
        check_eq("z_out_valid", {31'd0, z_out_valid}, 32'd1);
        z_in_a = 4'hA; z_in_b = 4'h5; z_out_ready = 1'b1;
        tick();
        z_in_valid = 1'b0;
        check_eq("z_no_early_done", {31'd0, z_frame_done}, 32'd0);
        check_eq("z_out_c2", {28'd0, z_out_c}, 32'h0);
        tick();
        check_eq("z_frame_done", {31'd0, z_frame_done}, 32'd1);
        check_eq("z_frame_parity", {31'd0, z_frame_parity}, 32'd0);
        tick();
        check_eq("z_frame_done_once", {31'd0, z_frame_done}, 32'd0);

        // WIDTH=1 frames: 1,1,1 -> parity 1; then 1,0,1 -> parity 0
        do_reset();
        f_out_ready = 1'b1;
        f_in_valid = 1'b1; f_in_a = 1'b1; f_in_b = 1'b0;
        tick();
        tick();
        check_eq("f_done_beat1", {31'd0, f_frame_done}, 32'd0);
        tick();
        f_in_valid = 1'b0;
        check_eq("f_done_beat2", {31'd0, f_frame_done}, 32'd0);
        tick();
        check_eq("f1_frame_done", {31'd0, f_frame_done}, 32'd1);
        check_eq("f1_frame_parity", {31'd0, f_frame_parity}, 32'd1);
        f_in_valid = 1'b1; f_in_a = 1'b1; f_in_b = 1'b0;
        tick();
        check_eq("f_done_pulse_end", {31'd0, f_frame_done}, 32'd0);
        check_eq("f_parity_hold", {31'd0, f_frame_parity}, 32'd1);
        f_in_a = 1'b1; f_in_b = 1'b1;
        tick();
        check_eq("f2_beat1_c", {31'd0, f_out_c}, 32'd0);
        f_in_a = 1'b0; f_in_b = 1'b1;
        tick();
        f_in_valid = 1'b0;
        check_eq("f2_beat2_done", {31'd0, f_frame_done}, 32'd0);
        tick();
        check_eq("f2_frame_done", {31'd0, f_frame_done}, 32'd1);
        check_eq("f2_frame_parity", {31'd0, f_frame_parity}, 32'd0);

        // Reset mid-frame: two beats delivered (acc=1) and buffer FULL, then reset
        do_reset();
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_a = 4'h8; a_in_b = 4'h0;
        tick();
        a_in_a = 4'h3;
        tick();
        a_in_a = 4'h5;
        tick();
        a_out_ready = 1'b0; a_in_a = 4'h6;
        tick();
        check_eq("mr_full", {31'd0, a_in_ready}, 32'd0);
        rst = 1'b1; a_in_valid = 1'b0;
        tick();
        rst = 1'b0;
        check_eq("mr_out_valid", {31'd0, a_out_valid}, 32'd0);
        check_eq("mr_in_ready", {31'd0, a_in_ready}, 32'd1);
        check_eq("mr_out_c", {28'd0, a_out_c}, 32'h0);
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_a = 4'h1; a_in_b = 4'h0;
        tick();
        a_in_a = 4'h2;
        tick();
        check_eq("mr_done_beat1", {31'd0, a_frame_done}, 32'd0);
        a_in_a = 4'h4;
        tick();
        a_in_valid = 1'b0;
        check_eq("mr_done_beat2", {31'd0, a_frame_done}, 32'd0);
        tick();
        check_eq("mr_frame_done", {31'd0, a_frame_done}, 32'd1);
        check_eq("mr_frame_parity", {31'd0, a_frame_parity}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
